uart_command_serializer: RTL and testbench
==========================================

Name: uart_command_serializer

Overview:
- Downstream stage of the UART command accumulator. Takes one packed command buffer (up to 128 bytes) with its byte count and streams it byte-by-byte to a UART transmitter over a valid/ready interface.
- Appends the link terminator: 0x0D on the BLE side, 0xBE 0xEF on the host side.
- Reports completion with `done` and aborts (undersize, oversize, transmitter stall) with `error`.

Parameters:
- `MAX_BYTES`, 128: largest legal `cmd_size`. Also the byte capacity of `cmd_data`.
- `BLE_TERM`, 8'h0D: terminator appended when `ble_side`=1.
- `HOST_TERM0`, 8'hBE: first terminator byte when `ble_side`=0.
- `HOST_TERM1`, 8'hEF: second terminator byte when `ble_side`=0.
- `TX_TIMEOUT`, 2000: consecutive stalled cycles (`tx_valid`=1, `tx_ready`=0) before abort. 0 disables the timeout.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `soft_reset` input 1: synchronous abort back to IDLE, active-high.
- `cmd_data` input 1024: command bytes. Byte k = `cmd_data[8k+7:8k]`; byte 0 is sent first.
- `cmd_size` input 8: number of valid bytes in `cmd_data`.
- `ble_side` input 1: selects the terminator. Sampled at command acceptance.
- `cmd_valid` input 1: a command is offered.
- `cmd_ready` output 1: block can accept a command. High only in IDLE.
- `tx_data` output 8: byte offered to the transmitter.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: transmitter accepts `tx_data` this cycle.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse when the full frame, including the terminator, has been accepted.
- `error` output 1: one-cycle pulse on a rejected or aborted command.

Behaviour:
- Reset (`reset_n`=0, asynchronous): state=IDLE, `cmd_ready`=1, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `done`=0, `error`=0. Byte index, timeout counter and the captured buffer, size and side are all cleared.
- Command acceptance: occurs on a cycle where `cmd_valid`=1 and `cmd_ready`=1 and `soft_reset`=0.
  - Capture `cmd_data`, `cmd_size` and `ble_side` into internal registers. Input changes after acceptance have no effect.
  - If `cmd_size`==0 or `cmd_size`>`MAX_BYTES`: on the next cycle pulse `error`=1, stay IDLE, emit no beats.
  - Otherwise: on the next cycle go to BODY with `tx_valid`=1, `tx_data`=byte 0, `busy`=1, `cmd_ready`=0.
- States:
  - IDLE: wait for a command.
  - BODY: send bytes 0..`cmd_size`-1.
  - TERM0: send `BLE_TERM` if `ble_side`=1, else `HOST_TERM0`.
  - TERM1: send `HOST_TERM1`. Host side only.
- Transmitter handshake:
  - A beat transfers on a cycle where `tx_valid`=1 and `tx_ready`=1.
  - While a beat is not taken, `tx_valid` stays high and `tx_data` stays stable.
  - After a transfer, the next beat is presented on the following cycle. Sustained throughput is 1 byte/cycle.
- Transitions on a transfer:
  - BODY: advance the index. After the last body byte, go to TERM0.
  - TERM0: on BLE side, finish. On host side, go to TERM1.
  - TERM1: finish.
- Finish: on the cycle after the final transfer, `done`=1 for one cycle, `tx_valid`=0, `busy`=0, `cmd_ready`=1, state=IDLE. A new command may be accepted in that same cycle.
- Beat count per frame: BLE side = `cmd_size`+1; host side = `cmd_size`+2.
- Terminator-valued bytes inside the body (e.g. 0x0D) are sent unmodified. No escaping is performed.
- Timeout:
  - The counter increments on every stalled cycle and clears on any transfer or on IDLE.
  - When `TX_TIMEOUT` stalled cycles have accumulated: on the next cycle `tx_valid`=0, `error`=1 for one cycle, state=IDLE, `cmd_ready`=1.
- `soft_reset`=1 in any state:
  - Next cycle: IDLE, `tx_valid`=0, `busy`=0. No `done` or `error`.
  - It overrides a simultaneous `cmd_valid`; the command is not captured.
  - It overrides a simultaneous final transfer; no `done`.
- `done` and `error` are never asserted in the same cycle.
- Index and size are 8 bits. `cmd_size`=128 is legal; the index reaches 127, and no wrap occurs.

Test Plan:
- BLE frame: `ble_side`=1, `cmd_size`=3, bytes 0x41 0x54 0x31, `tx_ready`=1 -> beats 41,54,31,0D on 4 consecutive cycles starting 1 cycle after acceptance; `done` pulses the cycle after 0D; `error` never asserted.
- Host frame with backpressure: `ble_side`=0, `cmd_size`=2, bytes 0x01 0x02, `tx_ready` toggling 1,0,1,0 -> beats 01,02,BE,EF; `tx_data` is held stable on every stalled cycle; exactly one `done` pulse.
- Full-size frame: `cmd_size`=128, byte k = k -> 128 body beats 00..7F, then BE,EF; `done`; no `error`.
- Illegal size: `cmd_size`=0, then `cmd_size`=129 -> each gives one `error` pulse, zero beats, `cmd_ready` back to 1.
- Stall timeout: `TX_TIMEOUT`=16, `tx_ready`=0 after byte 0 transfers -> `error` pulse after exactly 16 stalled cycles; `tx_valid` falls with it; a following legal command completes normally.
- Aborts: `reset_n` driven low mid-BODY -> all outputs take reset values immediately. `soft_reset` asserted mid-TERM0 -> IDLE next cycle with neither `done` nor `error`.

Source files
------------

// File: rtl/uart_command_serializer.sv
// Streams a captured command buffer byte-by-byte over a valid/ready link and
// appends the side-specific terminator; flags completion with done, aborts with error.
module uart_command_serializer #(
  parameter int          MAX_BYTES  = 128,
  parameter logic [7:0]  BLE_TERM   = 8'h0D,
  parameter logic [7:0]  HOST_TERM0 = 8'hBE,
  parameter logic [7:0]  HOST_TERM1 = 8'hEF,
  parameter int          TX_TIMEOUT = 2000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   soft_reset,
  input  logic [8*MAX_BYTES-1:0] cmd_data,
  input  logic [7:0]             cmd_size,
  input  logic                   ble_side,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    TERM0 = 2'd2,
    TERM1 = 2'd3
  } state_t;

  state_t                 state;
  logic [7:0]             idx;
  logic [7:0]             size_q;
  logic                   side_q;
  logic [8*MAX_BYTES-1:0] buf_q;
  logic [TW-1:0]          tmo_cnt;

  logic       accept;
  logic       xfer;
  logic       stall;
  logic       tmo_hit;
  logic       size_ok;
  logic       last_body;
  logic [7:0] body_byte;

  assign cmd_ready = (state == IDLE);
  assign tx_valid  = (state != IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready & ~soft_reset;
  assign xfer      = tx_valid & tx_ready;
  assign stall     = tx_valid & ~tx_ready;
  assign size_ok   = (cmd_size != 8'd0) && (int'(cmd_size) <= MAX_BYTES);
  assign last_body = (idx == size_q - 8'd1);
  // The stalled cycle that completes the TX_TIMEOUT-th stall triggers the abort.
  assign tmo_hit   = (TX_TIMEOUT != 0) && stall && (tmo_cnt == TW'(TX_TIMEOUT - 1));

  always_comb begin
    body_byte = '0;
    for (int unsigned k = 0; k < MAX_BYTES; k++) begin
      if (idx == 8'(k)) body_byte = buf_q[8*k +: 8];
    end
  end

  always_comb begin
    tx_data = '0;
    case (state)
      BODY:    tx_data = body_byte;
      TERM0:   tx_data = side_q ? BLE_TERM : HOST_TERM0;
      TERM1:   tx_data = HOST_TERM1;
      default: tx_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      size_q  <= '0;
      side_q  <= 1'b0;
      buf_q   <= '0;
      tmo_cnt <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (soft_reset) begin
        state   <= IDLE;
        idx     <= '0;
        tmo_cnt <= '0;
      end else if (state == IDLE) begin
        tmo_cnt <= '0;
        if (accept) begin
          buf_q  <= cmd_data;
          size_q <= cmd_size;
          side_q <= ble_side;
          idx    <= '0;
          if (size_ok) state <= BODY;
          else         error <= 1'b1;
        end
      end else if (tmo_hit) begin
        state   <= IDLE;
        idx     <= '0;
        tmo_cnt <= '0;
        error   <= 1'b1;
      end else begin
        if (xfer || TX_TIMEOUT == 0) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + 1'b1;
        if (xfer) begin
          case (state)
            BODY: begin
              if (last_body) begin
                state <= TERM0;
                idx   <= '0;
              end else begin
                idx <= idx + 8'd1;
              end
            end
            TERM0: begin
              if (side_q) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state <= TERM1;
              end
            end
            TERM1: begin
              state <= IDLE;
              done  <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_command_serializer.sv
// Randomized bench for uart_command_serializer: expected beat streams are built
// from the command bytes plus terminator and compared beat by beat.
module tb_uart_command_serializer;

  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          soft_reset = 1'b0;
  logic [1023:0] cmd_data = '0;
  logic [7:0]    cmd_size = '0;
  logic          ble_side = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          error;

  int errors = 0;
  int checks = 0;

  uart_command_serializer #(
    .MAX_BYTES (128),
    .BLE_TERM  (8'h0D),
    .HOST_TERM0(8'hBE),
    .HOST_TERM1(8'hEF),
    .TX_TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .soft_reset(soft_reset),
    .cmd_data  (cmd_data),
    .cmd_size  (cmd_size),
    .ble_side  (ble_side),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rand_buf();
    logic [1023:0] d;
    for (int k = 0; k < 32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) check_eq("cmd_ready_wait", cmd_ready, 1);
  endtask

  // mode: 0 = always ready, 1 = toggle 1,0,1,0, 2 = random.
  // sr_at >= 0: assert soft_reset together with tx_ready when beat sr_at is presented.
  task automatic run_frame(input logic side, input int size, input logic [1023:0] data,
                           input int mode, input int sr_at);
    byte unsigned exp_q[$];
    int pos = 0;
    int cyc = 0;
    logic legal;
    legal = (size >= 1) && (size <= 128);
    if (legal) begin
      for (int k = 0; k < size; k++) exp_q.push_back(data[8*k +: 8]);
      if (side) exp_q.push_back(8'h0D);
      else begin
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
      end
    end
    wait_ready();
    ble_side  = side;
    cmd_size  = 8'(size);
    cmd_data  = data;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_data  = rand_buf();
    cmd_size  = 8'($urandom);
    ble_side  = 1'($urandom);
    if (!legal) begin
      check_eq("bad_size_error", error, 1);
      check_eq("bad_size_tx_valid", tx_valid, 0);
      check_eq("bad_size_cmd_ready", cmd_ready, 1);
      check_eq("bad_size_busy", busy, 0);
      step();
      check_eq("bad_size_error_pulse", error, 0);
      check_eq("bad_size_no_beat", tx_valid, 0);
      return;
    end
    while (pos < exp_q.size() && cyc < 3000) begin
      check_eq("tx_valid", tx_valid, 1);
      check_eq("busy", busy, 1);
      check_eq("cmd_ready_busy", cmd_ready, 0);
      check_eq("early_done", done, 0);
      check_eq("frame_error", error, 0);
      check_eq("tx_data", tx_data, exp_q[pos]);
      if (sr_at == pos) begin
        tx_ready   = 1'b1;
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        tx_ready   = 1'b0;
        check_eq("sr_tx_valid", tx_valid, 0);
        check_eq("sr_busy", busy, 0);
        check_eq("sr_done", done, 0);
        check_eq("sr_error", error, 0);
        check_eq("sr_cmd_ready", cmd_ready, 1);
        step();
        check_eq("sr_done_late", done, 0);
        check_eq("sr_error_late", error, 0);
        return;
      end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2 == 0);
        default: tx_ready = 1'($urandom);
      endcase
      if (tx_ready) pos++;
      step();
      cyc++;
    end
    tx_ready = 1'b0;
    if (pos < exp_q.size()) check_eq("frame_budget", pos, exp_q.size());
    check_eq("done_pulse", done, 1);
    check_eq("done_tx_valid", tx_valid, 0);
    check_eq("done_busy", busy, 0);
    check_eq("done_cmd_ready", cmd_ready, 1);
    check_eq("done_no_error", error, 0);
    step();
    check_eq("done_one_cycle", done, 0);
  endtask

  task automatic run_timeout();
    logic [1023:0] d;
    int size;
    d    = rand_buf();
    size = $urandom_range(2, 40);
    wait_ready();
    ble_side  = 1'($urandom);
    cmd_size  = 8'(size);
    cmd_data  = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check_eq("tmo_byte0", tx_data, d[7:0]);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      check_eq("tmo_stall_valid", tx_valid, 1);
      check_eq("tmo_stall_hold", tx_data, d[15:8]);
      check_eq("tmo_stall_no_error", error, 0);
      step();
    end
    check_eq("tmo_error", error, 1);
    check_eq("tmo_tx_valid", tx_valid, 0);
    check_eq("tmo_cmd_ready", cmd_ready, 1);
    check_eq("tmo_no_done", done, 0);
    step();
    check_eq("tmo_error_pulse", error, 0);
  endtask

  task automatic run_async_reset();
    logic [1023:0] d;
    d = rand_buf();
    wait_ready();
    ble_side  = 1'b0;
    cmd_size  = 8'd10;
    cmd_data  = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    tx_ready  = 1'b1;
    repeat (3) step();
    check_eq("pre_rst_data", tx_data, d[31:24]);
    reset_n = 1'b0;
    #1;
    check_eq("arst_cmd_ready", cmd_ready, 1);
    check_eq("arst_tx_valid", tx_valid, 0);
    check_eq("arst_tx_data", tx_data, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_error", error, 0);
    tx_ready = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic run_sr_vs_cmd(input int size);
    wait_ready();
    cmd_size   = 8'(size);
    cmd_data   = rand_buf();
    ble_side   = 1'b1;
    cmd_valid  = 1'b1;
    soft_reset = 1'b1;
    step();
    cmd_valid  = 1'b0;
    soft_reset = 1'b0;
    check_eq("sr_cmd_tx_valid", tx_valid, 0);
    check_eq("sr_cmd_busy", busy, 0);
    check_eq("sr_cmd_error", error, 0);
    check_eq("sr_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    logic [1023:0] d;
    reset_n = 1'b0;
    step();
    step();
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    reset_n = 1'b1;
    step();

    d = '0;
    d[23:0] = 24'h315441;
    run_frame(1'b1, 3, d, 0, -1);

    d = '0;
    d[15:0] = 16'h0201;
    run_frame(1'b0, 2, d, 1, -1);

    for (int k = 0; k < 128; k++) d[8*k +: 8] = 8'(k);
    run_frame(1'b0, 128, d, 0, -1);

    run_frame(1'b1, 0, rand_buf(), 0, -1);
    run_frame(1'b0, 129, rand_buf(), 0, -1);
    run_frame(1'b1, $urandom_range(130, 255), rand_buf(), 0, -1);

    d = '0;
    d[31:0] = 32'h0D0DBEEF;
    run_frame(1'b1, 4, d, 2, -1);

    run_timeout();
    run_frame(1'b1, 5, rand_buf(), 0, -1);

    run_async_reset();
    run_frame(1'b0, 7, rand_buf(), 2, -1);

    run_frame(1'b1, 6, rand_buf(), 0, 6);
    run_frame(1'b0, 6, rand_buf(), 2, 6);
    run_frame(1'b0, 9, rand_buf(), 0, 10);
    run_sr_vs_cmd(5);
    run_sr_vs_cmd(0);

    for (int n = 0; n < 25; n++) begin
      int size;
      size = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 128) : $urandom_range(1, 12);
      run_frame(1'($urandom), size, rand_buf(), $urandom_range(0, 2), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
